// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default operand width and FSM encoding.
package div_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB when it does not go negative.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    logic           borrow;
    logic           unused_diff_msb;

    // The shifted remainder needs WIDTH+1 bits; the extra borrow bit keeps a zero
    // divisor from being mistaken for a negative result.
    always_comb begin
        partial          = {rem_i, quo_i[WIDTH-1]};
        {borrow, diff}   = {1'b0, partial} - {2'b00, div_i};
        rem_o            = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_o            = {quo_i[WIDTH-2:0], ~borrow};
    end

    // A kept difference is always below the divisor, so its top bit is zero.
    assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: one restoring step per cycle, sign fix-up at the end.
// Result = {remainder, quotient}; Done pulses WIDTH+2 cycles after Start is accepted.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Result
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   step_rem, step_quo;
    logic               a_neg, b_neg;

    assign a_neg = Signed & A[WIDTH-1];
    assign b_neg = Signed & B[WIDTH-1];

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state and datapath updates for each FSM state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    // Magnitudes as unsigned, so the most-negative value becomes 2^(WIDTH-1).
                    quo_d     = a_neg ? -A : A;
                    dvs_d     = b_neg ? -B : B;
                    rem_d     = '0;
                    cnt_d     = CntW'(WIDTH);
                    // Divide by zero keeps the all-ones quotient regardless of signs.
                    neg_quo_d = (a_neg ^ b_neg) && (|B);
                    neg_rem_d = a_neg;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -quo_q : quo_q};
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign Busy   = (state_q == StCalc) || (state_q == StFix);
    assign Done   = (state_q == StDone);
    assign Result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, random ops and multi-cycle corner cases.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic           Clk = 1'b0;
    logic           Reset, Start, Signed;
    logic [W-1:0]   A, B;
    logic           Busy, Done;
    logic [2*W-1:0] Result;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Signed (Signed),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [63:0] res;
        int          acc;
    } exp_t;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
    } vec_t;

    exp_t        scb[$];
    vec_t        vecs[13];
    logic [63:0] last_res;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every Done pops one expected result.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset === 1'b1 && Done === 1'b1) begin
            if (scb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got Done=1 want no Done (t=%0t)", $time);
            end else begin
                e = scb.pop_front();
                check("result", Result, e.res);
                check("latency_edge", 64'(edge_cnt + 1), 64'(e.acc + int'(W) + 2));
                check("busy_in_done", {63'd0, Busy}, 64'd0);
            end
        end
    end

    task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp, input bit push);
        @(negedge Clk);
        Start  = 1'b1;
        Signed = sgn;
        A      = a;
        B      = b;
        if (push) scb.push_back('{res: exp, acc: edge_cnt + 1});
        @(negedge Clk);
        Start  = 1'b0;
        Signed = ~sgn;
        A      = $urandom;
        B      = $urandom;
        check("busy_after_accept", {63'd0, Busy}, 64'd1);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < int'(W) + 10 && !seen; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no Done want Done within %0d cycles", W + 10);
        end
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp);
        bit seen;
        launch(sgn, a, b, exp, 1'b1);
        wait_done(seen);
        @(negedge Clk);
        check("done_one_cycle", {63'd0, Done}, 64'd0);
        check("result_hold", Result, exp);
        last_res = exp;
    endtask

    initial begin
        bit          seen;
        logic [31:0] ua, ub;
        int          sa, sbv;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{1'b0, 32'h1234,       32'd0,          64'h00001234_FFFFFFFF};
        vecs[3]  = '{1'b1, 32'h1234,       32'd0,          64'h00001234_FFFFFFFF};
        vecs[4]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'hFFFFFFF9_FFFFFFFF};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd10,         64'h00000005_19999999};
        vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003};
        vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
        vecs[10] = '{1'b1, 32'h80000000,   32'd3,          64'hFFFFFFFE_D5555556};
        vecs[11] = '{1'b0, 32'd0,          32'd5,          64'h00000000_00000000};
        vecs[12] = '{1'b0, 32'd5,          32'd5,          64'h00000000_00000001};

        // Reset state, with Start asserted during reset to show reset wins.
        Reset  = 1'b0;
        Start  = 1'b0;
        Signed = 1'b0;
        A      = '0;
        B      = '0;
        @(negedge Clk);
        Start = 1'b1;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge Clk);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);
        check("reset_result", Result, 64'd0);
        Start = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_start_ignored", {63'd0, Busy}, 64'd0);

        foreach (vecs[i]) run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res);

        // Start while busy is ignored; old Result holds until the new FIX.
        launch(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
        repeat (3) @(negedge Clk);
        check("result_hold_calc", Result, last_res);
        @(negedge Clk);
        Start  = 1'b1;
        Signed = 1'b1;
        A      = 32'hFFFFFFF9;
        B      = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        check("busy_start_ignored", {63'd0, Busy}, 64'd1);
        wait_done(seen);
        @(negedge Clk);
        repeat (40) @(negedge Clk);
        check("busy_ignored_result", Result, 64'h00000002_0000000E);

        // Start in the DONE cycle is ignored.
        launch(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
        wait_done(seen);
        Start  = 1'b1;
        Signed = 1'b0;
        A      = 32'd5;
        B      = 32'd1;
        @(negedge Clk);
        Start = 1'b0;
        check("done_start_ignored", {63'd0, Busy}, 64'd0);
        repeat (40) @(negedge Clk);
        check("done_start_result", Result, 64'hFFFFFFFF_FFFFFFFD);

        // Reset at edge 10 of an operation abandons it.
        launch(1'b0, 32'hDEADBEEF, 32'd3, 64'd0, 1'b0);
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("midreset_busy", {63'd0, Busy}, 64'd0);
        check("midreset_done", {63'd0, Done}, 64'd0);
        check("midreset_result", Result, 64'd0);
        Reset = 1'b1;
        repeat (45) @(negedge Clk);
        run_op(1'b0, 32'd1000, 32'd10, 64'h00000000_00000064);

        // Random unsigned operations against a behavioural model.
        for (int i = 0; i < 6; i++) begin
            ua = $urandom;
            ub = $urandom >> $urandom_range(0, 31);
            if (ub == 0) ub = 32'd1;
            run_op(1'b0, ua, ub, {ua % ub, ua / ub});
        end

        // Random signed operations; integer / and % truncate toward zero.
        for (int i = 0; i < 6; i++) begin
            sa  = $urandom;
            sbv = int'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) sbv = -sbv;
            if (sa == 32'sh80000000 && sbv == -1) sbv = 2;
            run_op(1'b1, sa, sbv, {32'(sa % sbv), 32'(sa / sbv)});
        end

        repeat (5) @(negedge Clk);
        check("scoreboard_drain", 64'(scb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
